// File: rtl/amber128_bundle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// amber128_bundle_sequencer_pkg
// Shared constants and types for the amber128 fetch-to-decode bundle
// sequencer: default bundle geometry, the issued-slot record that feeds the
// decode stage, and a small index-width helper.
// ---------------------------------------------------------------------------
package amber128_bundle_sequencer_pkg;

  localparam int AMBER128_BUNDLE_W   = 128;
  localparam int AMBER128_SLOT_COUNT = 5;
  localparam int AMBER128_SLOT_W     = 24;

  // One issued slot in the default 5 x 24-bit format (feeds amber128_decode_s).
  typedef struct packed {
    logic        valid;
    logic [63:0] pc_word_addr;
    logic [2:0]  slot_idx;
    logic [23:0] payload;
    logic        last;
  } amber128_slot_s;

  // Slot index width, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/amber128_bundle_sequencer_if.sv
// ---------------------------------------------------------------------------
// amber128_bundle_sequencer_if
// Fetch-side and slot-side handshake bundle of the sequencer.
//   slave  : sequencer view (takes fetch bundles, issues slots)
//   master : environment view (offers fetch bundles, consumes slots)
// Signals: fetch_valid_i/fetch_ready_o/fetch_addr_i/fetch_bundle_i,
//          slot_valid_o/slot_ready_i/slot_pc_o/slot_idx_o/slot_payload_o/
//          slot_last_o
// ---------------------------------------------------------------------------
interface amber128_bundle_sequencer_if #(
  parameter int BUNDLE_W = 128,
  parameter int SLOT_W   = 24,
  parameter int IDX_W    = 3
);
  logic                fetch_valid_i;
  logic                fetch_ready_o;
  logic [63:0]         fetch_addr_i;
  logic [BUNDLE_W-1:0] fetch_bundle_i;
  logic                slot_valid_o;
  logic                slot_ready_i;
  logic [63:0]         slot_pc_o;
  logic [IDX_W-1:0]    slot_idx_o;
  logic [SLOT_W-1:0]   slot_payload_o;
  logic                slot_last_o;

  modport slave (
    input  fetch_valid_i, fetch_addr_i, fetch_bundle_i, slot_ready_i,
    output fetch_ready_o, slot_valid_o, slot_pc_o, slot_idx_o,
           slot_payload_o, slot_last_o
  );

  modport master (
    output fetch_valid_i, fetch_addr_i, fetch_bundle_i, slot_ready_i,
    input  fetch_ready_o, slot_valid_o, slot_pc_o, slot_idx_o,
           slot_payload_o, slot_last_o
  );
endinterface

// File: rtl/amber128_bundle_fifo.sv
// ---------------------------------------------------------------------------
// amber128_bundle_fifo
// Bundle storage for the sequencer: QDEPTH entries of {addr, data, mask}.
// The head mask is writable so the sequencer can retire slots in place.
// Ports: clk_i, rst_ni (sync, active-low), flush_i, push_i/push_*,
//        pop_i, mask_we_i/mask_wdata_i (head mask update),
//        count_o, empty_o, head_addr_o, head_data_o, head_mask_o
// Callers never push when full, never pop/write the mask when empty, and
// never push or write the mask during flush.
// ---------------------------------------------------------------------------
module amber128_bundle_fifo
  import amber128_bundle_sequencer_pkg::*;
#(
  parameter  int QDEPTH = 2,
  parameter  int DATA_W = 120,
  parameter  int MASK_W = 5,
  localparam int CNT_W  = $clog2(QDEPTH + 1),
  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [63:0]       push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [MASK_W-1:0] push_mask_i,
  input  logic              pop_i,
  input  logic              mask_we_i,
  input  logic [MASK_W-1:0] mask_wdata_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic [63:0]       head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [MASK_W-1:0] head_mask_o
);

  logic [63:0]       r_addr [QDEPTH];
  logic [DATA_W-1:0] r_data [QDEPTH];
  logic [MASK_W-1:0] r_mask [QDEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Push and head-mask writes never hit the same entry: a push needs a free
  // slot, a mask write needs an occupied head.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_addr[r_wr_ptr] <= push_addr_i;
      r_data[r_wr_ptr] <= push_data_i;
      r_mask[r_wr_ptr] <= push_mask_i;
    end
    if (mask_we_i) r_mask[r_rd_ptr] <= mask_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop_i)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign count_o     = r_count;
  assign empty_o     = (r_count == '0);
  assign head_addr_o = r_addr[r_rd_ptr];
  assign head_data_o = r_data[r_rd_ptr];
  assign head_mask_o = r_mask[r_rd_ptr];

endmodule

// File: rtl/amber128_bundle_sequencer.sv
// ---------------------------------------------------------------------------
// amber128_bundle_sequencer
// Buffers fetch bundles and issues their flagged slots one per cycle in
// ascending order, with flush and redirect into the middle of a bundle.
// Ports: clk_i, rst_ni (sync, active-low), flush_i, redirect_slot_i,
//        bus (amber128_bundle_sequencer_if.slave: fetch + slot handshakes)
// Optional macro AMBER128_BSEQ_PERF_EN adds perf_issued_o, perf_skipped_o,
//        perf_bubble_o (32-bit wrapping counters, cleared by reset only).
// ---------------------------------------------------------------------------
module amber128_bundle_sequencer
  import amber128_bundle_sequencer_pkg::*;
#(
  parameter int BUNDLE_W   = AMBER128_BUNDLE_W,
  parameter int SLOT_COUNT = AMBER128_SLOT_COUNT,
  parameter int SLOT_W     = AMBER128_SLOT_W,
  parameter int QDEPTH     = 2,
  parameter int IDX_W      = idx_width(SLOT_COUNT)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [IDX_W-1:0]              redirect_slot_i,
  amber128_bundle_sequencer_if.slave    bus
`ifdef AMBER128_BSEQ_PERF_EN
  ,
  output logic [31:0]                   perf_issued_o,
  output logic [31:0]                   perf_skipped_o,
  output logic [31:0]                   perf_bubble_o
`endif
);

  localparam int PAY_W = SLOT_COUNT * SLOT_W;
  localparam int GAP_W = BUNDLE_W - SLOT_COUNT - PAY_W;
  localparam int CNT_W = $clog2(QDEPTH + 1);
`ifdef AMBER128_BSEQ_PERF_EN
  localparam int DATA_W = PAY_W + SLOT_COUNT;  // enqueue mask rides along
`else
  localparam int DATA_W = PAY_W;
`endif
  localparam logic [SLOT_COUNT-1:0] ALL_ONES = {SLOT_COUNT{1'b1}};

  if (GAP_W < 0) begin : g_bad_geometry
    $error("amber128_bundle_sequencer: slots plus flags exceed BUNDLE_W");
  end

  if (GAP_W > 0) begin : g_gap
    logic w_unused_gap;
    assign w_unused_gap = ^bus.fetch_bundle_i[PAY_W +: GAP_W];
  end

  logic [SLOT_COUNT-1:0] w_flags, w_enq_mask, w_head_mask, w_clr_mask, w_next_mask;
  logic [IDX_W-1:0]      r_start_idx, w_head_idx;
  logic [CNT_W-1:0]      w_count;
  logic [63:0]           w_head_addr;
  logic [DATA_W-1:0]     w_head_data, w_push_data;
  logic                  w_ready, w_push, w_pop, w_empty, w_any, w_last;
  logic                  w_slot_valid, w_slot_fire;

  assign w_flags    = bus.fetch_bundle_i[BUNDLE_W-1 -: SLOT_COUNT];
  // A start index at or beyond SLOT_COUNT shifts every bit out: bundle dropped.
  assign w_enq_mask = w_flags & (ALL_ONES << r_start_idx);
  assign w_ready    = (w_count < CNT_W'(QDEPTH)) & !flush_i;
  assign w_push     = bus.fetch_valid_i & w_ready;
`ifdef AMBER128_BSEQ_PERF_EN
  assign w_push_data = {w_enq_mask, bus.fetch_bundle_i[PAY_W-1:0]};
`else
  assign w_push_data = bus.fetch_bundle_i[PAY_W-1:0];
`endif

  always_comb begin
    w_head_idx = '0;
    for (int k = SLOT_COUNT - 1; k >= 0; k--)
      if (w_head_mask[k]) w_head_idx = IDX_W'(k);
  end

  assign w_any        = |w_head_mask;
  assign w_last       = w_any & ((w_head_mask & (w_head_mask - 1'b1)) == '0);
  assign w_slot_valid = !w_empty & w_any & !flush_i;
  assign w_slot_fire  = w_slot_valid & bus.slot_ready_i;
  assign w_clr_mask   = SLOT_COUNT'(1) << w_head_idx;
  assign w_next_mask  = w_head_mask & ~w_clr_mask;
  // Retire the head on its last slot, or after one idle cycle if nothing was
  // left to issue.
  assign w_pop = !flush_i & !w_empty & (!w_any | (w_slot_fire & (w_next_mask == '0)));

  always_ff @(posedge clk_i) begin
    if (!rst_ni)      r_start_idx <= '0;
    else if (flush_i) r_start_idx <= redirect_slot_i;
    else if (w_push)  r_start_idx <= '0;
  end

  amber128_bundle_fifo #(
    .QDEPTH (QDEPTH),
    .DATA_W (DATA_W),
    .MASK_W (SLOT_COUNT)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_i       (w_push),
    .push_addr_i  (bus.fetch_addr_i),
    .push_data_i  (w_push_data),
    .push_mask_i  (w_enq_mask),
    .pop_i        (w_pop),
    .mask_we_i    (w_slot_fire),
    .mask_wdata_i (w_next_mask),
    .count_o      (w_count),
    .empty_o      (w_empty),
    .head_addr_o  (w_head_addr),
    .head_data_o  (w_head_data),
    .head_mask_o  (w_head_mask)
  );

  assign bus.fetch_ready_o  = w_ready;
  assign bus.slot_valid_o   = w_slot_valid;
  assign bus.slot_pc_o      = w_slot_valid ? w_head_addr : '0;
  assign bus.slot_idx_o     = w_slot_valid ? w_head_idx : '0;
  assign bus.slot_payload_o = w_slot_valid ? w_head_data[w_head_idx*SLOT_W +: SLOT_W] : '0;
  assign bus.slot_last_o    = w_slot_valid & w_last;

`ifdef AMBER128_BSEQ_PERF_EN
  logic [31:0]           r_perf_issued, r_perf_skipped, r_perf_bubble;
  logic [SLOT_COUNT-1:0] w_head_enq_mask;

  assign w_head_enq_mask = w_head_data[DATA_W-1 -: SLOT_COUNT];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf_issued  <= '0;
      r_perf_skipped <= '0;
      r_perf_bubble  <= '0;
    end else begin
      if (w_slot_fire) r_perf_issued <= r_perf_issued + 32'd1;
      if (w_pop)
        r_perf_skipped <= r_perf_skipped + 32'(SLOT_COUNT - $countones(w_head_enq_mask));
      if (!w_empty && !w_slot_valid && !flush_i) r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign perf_issued_o  = r_perf_issued;
  assign perf_skipped_o = r_perf_skipped;
  assign perf_bubble_o  = r_perf_bubble;
`endif

endmodule
